// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory initiator: funct3 codes,
// FSM state encoding and the request legality check.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_STORE  = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // A request that must be rejected without touching memory.
    function automatic logic req_illegal(input logic       is_load,
                                         input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (is_load && is_store) begin
            bad = 1'b1;
        end else begin
            case (funct3)
                F3_B:          bad = 1'b0;
                F3_H:          bad = off[0];
                F3_W:          bad = (off != 2'b00);
                F3_BU, F3_HU:  bad = is_store;
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane handling for a word-wide memory: extracts and extends load
// values, and merges sub-word store data into an existing word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'h0, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'h0, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_funct3)
            F3_B: o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_off[1]) o_merged[31:16] = i_wdata;
                else          o_merged[15:0]  = i_wdata;
            end
            default: o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-addressed data memory. Sub-word stores run as
// read-modify-write; illegal or misaligned requests are answered with an error.
//
// Handshake: a request is taken when req_valid && req_ready && (req_load || req_store);
// req_ready is high only in IDLE. Completion is a single-cycle rsp_valid pulse with
// no back-pressure; rsp_rdata/rsp_error are meaningful only during that pulse.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output state_t            dbg_state
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W+1:0]   r_addr;
    logic [2:0]          r_funct3;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merge;
    logic                r_rsp_valid;
    logic                r_rsp_error;
    logic [31:0]         r_rsp_rdata;

    logic                w_accept;
    logic                w_illegal;
    logic [31:0]         w_load;
    logic [31:0]         w_merged;
    logic                w_unused_addr;

    // Address bits above the memory span are deliberately dropped (wrap-around).
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    assign w_accept  = req_valid && (r_state == ST_IDLE) && (req_load || req_store);
    assign w_illegal = req_illegal(req_load, req_store, req_funct3, req_addr[1:0]);

    mem_lane_align u_align (
        .i_word   (mem_rdata),
        .i_wdata  (r_wdata[15:0]),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_illegal)              w_next = ST_ERR;
                    else if (req_load)          w_next = ST_LOAD;
                    else if (req_funct3 == F3_W) w_next = ST_STORE;
                    else                        w_next = ST_RMW_RD;
                end
            end
            ST_RMW_RD: w_next = ST_RMW_WR;
            ST_LOAD, ST_RMW_WR, ST_STORE, ST_ERR: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        mem_read  = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
        mem_write = (r_state == ST_STORE) || (r_state == ST_RMW_WR);
        case (r_state)
            ST_STORE:  mem_wdata = r_wdata;
            ST_RMW_WR: mem_wdata = r_merge;
            default:   mem_wdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_funct3    <= 3'b000;
            r_wdata     <= 32'h0;
            r_merge     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= 32'h0;
            if (w_accept) begin
                r_addr   <= req_addr[ADDR_W+1:0];
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
            end
            case (r_state)
                ST_LOAD: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_load;
                end
                ST_RMW_RD: r_merge <= w_merged;
                ST_RMW_WR, ST_STORE: r_rsp_valid <= 1'b1;
                ST_ERR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_addr[ADDR_W+1:2];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_load = 1'b0;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    state_t            dbg_state;

    logic [31:0] mem [64];
    logic        preload = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // ---- clock / reset block
    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---- memory model
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'd17;
            mem[1] <= 32'd9;
            mem[2] <= 32'd25;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

    // ---- checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- driver tasks (called at a negedge while the unit is in IDLE)
    task automatic start(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        check("req_ready_at_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
    endtask

    task automatic expect_load(input string tag, input logic [ADDR_W-1:0] waddr,
                               input logic [31:0] data);
        check({tag, "_rd_n1"}, 32'(mem_read), 32'd1);
        check({tag, "_wr_n1"}, 32'(mem_write), 32'd0);
        check({tag, "_addr_n1"}, 32'(mem_addr), 32'(waddr));
        check({tag, "_ready_n1"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_valid_n2"}, 32'(rsp_valid), 32'd1);
        check({tag, "_err_n2"}, 32'(rsp_error), 32'd0);
        check({tag, "_rdata_n2"}, rsp_rdata, data);
        check({tag, "_rd_n2"}, 32'(mem_read), 32'd0);
    endtask

    task automatic expect_sw(input string tag, input logic [ADDR_W-1:0] waddr,
                             input logic [31:0] wd);
        check({tag, "_wr_n1"}, 32'(mem_write), 32'd1);
        check({tag, "_rd_n1"}, 32'(mem_read), 32'd0);
        check({tag, "_addr_n1"}, 32'(mem_addr), 32'(waddr));
        check({tag, "_wdata_n1"}, mem_wdata, wd);
        @(negedge clk);
        check({tag, "_valid_n2"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rdata_n2"}, rsp_rdata, 32'h0);
        check({tag, "_wr_n2"}, 32'(mem_write), 32'd0);
    endtask

    task automatic expect_rmw(input string tag, input logic [ADDR_W-1:0] waddr,
                              input logic [31:0] merged);
        check({tag, "_rd_n1"}, 32'(mem_read), 32'd1);
        check({tag, "_wr_n1"}, 32'(mem_write), 32'd0);
        check({tag, "_addr_n1"}, 32'(mem_addr), 32'(waddr));
        check({tag, "_valid_n1"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_wr_n2"}, 32'(mem_write), 32'd1);
        check({tag, "_rd_n2"}, 32'(mem_read), 32'd0);
        check({tag, "_wdata_n2"}, mem_wdata, merged);
        check({tag, "_valid_n2"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid_n3"}, 32'(rsp_valid), 32'd1);
        check({tag, "_err_n3"}, 32'(rsp_error), 32'd0);
        check({tag, "_mem_word"}, mem[waddr], merged);
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_rd_n1"}, 32'(mem_read), 32'd0);
        check({tag, "_wr_n1"}, 32'(mem_write), 32'd0);
        check({tag, "_valid_n1"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid_n2"}, 32'(rsp_valid), 32'd1);
        check({tag, "_err_n2"}, 32'(rsp_error), 32'd1);
        check({tag, "_rdata_n2"}, rsp_rdata, 32'h0);
        check({tag, "_rd_n2"}, 32'(mem_read), 32'd0);
        check({tag, "_wr_n2"}, 32'(mem_write), 32'd0);
    endtask

    // ---- directed sequence
    initial begin
        preload = 1'b1;
        @(negedge clk);
        @(negedge clk);
        preload = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_error", 32'(rsp_error), 32'd0);
        check("rst_rd", 32'(mem_read), 32'd0);
        check("rst_wr", 32'(mem_write), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        start(1'b1, 1'b0, F3_W, 32'h8, 32'h0);
        expect_load("lw_8", 6'd2, 32'd25);
        @(negedge clk);
        check("lw_8_valid_drop", 32'(rsp_valid), 32'd0);
        check("lw_8_rdata_drop", rsp_rdata, 32'h0);

        // sb, then back-to-back loads accepted in each response cycle
        start(1'b0, 1'b1, F3_B, 32'h5, 32'h0000_00AB);
        expect_rmw("sb_5", 6'd1, 32'h0000_AB09);
        start(1'b1, 1'b0, F3_B, 32'h5, 32'h0);
        expect_load("lb_5", 6'd1, 32'hFFFF_FFAB);
        start(1'b1, 1'b0, F3_BU, 32'h5, 32'h0);
        expect_load("lbu_5", 6'd1, 32'h0000_00AB);
        start(1'b1, 1'b0, F3_W, 32'h108, 32'h0);
        expect_load("lw_wrap", 6'd2, 32'd25);
        @(negedge clk);

        // reset during the read half of an sb to word 0
        start(1'b0, 1'b1, F3_B, 32'h0, 32'h0000_0055);
        check("abort_rd", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rd_drop", 32'(mem_read), 32'd0);
        check("abort_wr_drop", 32'(mem_write), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_wr", 32'(mem_write), 32'd0);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("abort_word0", mem[0], 32'd17);

        start(1'b0, 1'b1, F3_H, 32'h2, 32'h0000_1234);
        expect_rmw("sh_2", 6'd0, 32'h1234_0011);
        start(1'b1, 1'b0, F3_HU, 32'h2, 32'h0);
        expect_load("lhu_2", 6'd0, 32'h0000_1234);

        start(1'b0, 1'b1, F3_W, 32'h10, 32'h80FF_7F01);
        expect_sw("sw_10", 6'd4, 32'h80FF_7F01);
        start(1'b1, 1'b0, F3_H, 32'h12, 32'h0);
        expect_load("lh_12", 6'd4, 32'hFFFF_80FF);
        start(1'b1, 1'b0, F3_B, 32'h11, 32'h0);
        expect_load("lb_11", 6'd4, 32'h0000_007F);
        start(1'b1, 1'b0, F3_B, 32'h13, 32'h0);
        expect_load("lb_13", 6'd4, 32'hFFFF_FF80);
        start(1'b1, 1'b0, F3_HU, 32'h10, 32'h0);
        expect_load("lhu_10", 6'd4, 32'h0000_7F01);

        // rejected requests
        start(1'b1, 1'b0, F3_H, 32'h3, 32'h0);
        expect_err("lh_3");
        start(1'b0, 1'b1, F3_W, 32'h6, 32'hFFFF_FFFF);
        expect_err("sw_6");
        start(1'b1, 1'b1, F3_W, 32'h8, 32'h0);
        expect_err("ld_st");
        start(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        expect_err("f3_011");
        start(1'b0, 1'b1, F3_BU, 32'h4, 32'h0);
        expect_err("sbu");
        check("err_word1", mem[1], 32'h0000_AB09);
        @(negedge clk);

        // request with neither load nor store is ignored
        req_valid = 1'b1;
        @(negedge clk);
        check("ign_state", 32'(dbg_state), 32'(ST_IDLE));
        check("ign_rd", 32'(mem_read), 32'd0);
        @(negedge clk);
        check("ign_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;

        start(1'b1, 1'b0, F3_W, 32'h4, 32'h0);
        expect_load("lw_4_final", 6'd1, 32'h0000_AB09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
